// File: rtl/core_pkg.sv
// Mini-core shared types and defaults.
// Holds the store-stage state enum and memory width defaults.
package core_pkg;

  localparam int ADR_W  = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2,
    ST_HALT  = 2'd3
  } st_state_t;

endpackage

// File: rtl/st.sv
// Store stage: writes an 8/16-bit result to a byte-wide data memory,
// one byte per cycle, freezing upstream while busy; tracks halt.
// Ports: clk, rst (async high); in_valid, data_mem_write, mul_or_add,
//   halted, write_adr, result in; mem_we/mem_adr/mem_wdata to memory;
//   freeze, st_done, halted_out, wr_count status out.
module st
  import core_pkg::*;
#(
  parameter int ADR_W  = core_pkg::ADR_W,
  parameter int DATA_W = core_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                data_mem_write,
  input  logic                mul_or_add,
  input  logic                halted,
  input  logic [ADR_W-1:0]    write_adr,
  input  logic [2*DATA_W-1:0] result,
  output logic                mem_we,
  output logic [ADR_W-1:0]    mem_adr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                freeze,
  output logic                st_done,
  output logic                halted_out,
  output logic [7:0]          wr_count
);

  st_state_t state, state_nx;

  logic [ADR_W-1:0]    adr_q;
  logic [2*DATA_W-1:0] res_q;
  logic                mul_q;
  logic                halt_pend;
  logic                accept;

  assign accept = (state == ST_IDLE) && in_valid && data_mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (data_mem_write) state_nx = ST_WR_LO;
          else if (halted)    state_nx = ST_HALT;
        end
      end
      ST_WR_LO: begin
        if (mul_q)          state_nx = ST_WR_HI;
        else if (halt_pend) state_nx = ST_HALT;
        else                state_nx = ST_IDLE;
      end
      ST_WR_HI: begin
        state_nx = halt_pend ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q     <= '0;
      res_q     <= '0;
      mul_q     <= 1'b0;
      halt_pend <= 1'b0;
    end else if (accept) begin
      adr_q     <= write_adr;
      res_q     <= result;
      mul_q     <= mul_or_add;
      halt_pend <= halted;
    end
  end

  // Outputs are decoded from state and holding flops only.
  always_comb begin
    mem_we     = 1'b0;
    mem_adr    = '0;
    mem_wdata  = '0;
    st_done    = 1'b0;
    freeze     = (state != ST_IDLE);
    halted_out = (state == ST_HALT);
    unique case (state)
      ST_WR_LO: begin
        mem_we    = 1'b1;
        mem_adr   = adr_q;
        mem_wdata = res_q[DATA_W-1:0];
        st_done   = ~mul_q;
      end
      ST_WR_HI: begin
        mem_we    = 1'b1;
        mem_adr   = adr_q + 1'b1;
        mem_wdata = res_q[2*DATA_W-1:DATA_W];
        st_done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wr_count <= '0;
    else if (mem_we && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
  end

endmodule

// File: doc/st.md
# st

Store stage of the Mini-core pipeline: the write-side counterpart to the load pipeline register. Accepts a store request (address, 8- or 16-bit result, halt flag) from the execute stage, then drives the single-port, byte-wide data memory one byte per cycle. While a store is in progress it freezes the upstream pipeline. It also tracks halt and counts bytes written.

## Interface
Parameters:
- ADR_W, 6, data-memory address width
- DATA_W, 8, memory byte width; the result is 2*DATA_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present this cycle
- data_mem_write  in  1  request is a store
- mul_or_add  in  1  1 = mul (16-bit result, two bytes), 0 = add (8-bit, one byte)
- halted  in  1  request carries halt
- write_adr  in  ADR_W  base byte address
- result  in  2*DATA_W  store data; low byte used for add
- mem_we  out  1  data-memory write enable
- mem_adr  out  ADR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- freeze  out  1  upstream must hold its registers
- st_done  out  1  one-cycle pulse on the last byte of a store
- halted_out  out  1  sticky halt indication
- wr_count  out  8  bytes written since reset, saturating

## Operation
- States: IDLE, WR_LO, WR_HI, HALT. All outputs are decoded from flops only; no input-to-output combinational path.
- IDLE, in_valid=1:
  - If data_mem_write=1: capture adr, result, mul_or_add and halted into holding registers (halted goes to halt_pend). Go to WR_LO.
  - Else if halted=1: go to HALT.
  - Else: stay in IDLE; no memory activity.
- in_valid is ignored in every state other than IDLE. Upstream holds its request while freeze=1.
- WR_LO: mem_we=1, mem_adr=adr, mem_wdata=result[7:0].
  - mul: go to WR_HI.
  - add: st_done=1; go to HALT if halt_pend, else IDLE.
- WR_HI: mem_we=1, mem_adr=(adr+1) mod 2^ADR_W (address 63 wraps to 0), mem_wdata=result[15:8], st_done=1. Then go to HALT if halt_pend, else IDLE.
- HALT: terminal state until rst. halted_out=1, freeze=1, mem_we=0, all input ignored.
- freeze=1 in WR_LO, WR_HI and HALT; 0 in IDLE.
- wr_count increments by 1 in every cycle with mem_we=1 and saturates at 255.
- A halt that arrives with a store never drops the pending store: all bytes are written, then the block enters HALT.

## Timing
- Reset values: state=IDLE; mem_we=0, mem_adr=0, mem_wdata=0, freeze=0, st_done=0, halted_out=0, wr_count=0; holding registers and halt_pend=0.
- Request accepted at edge k:
  - add: byte written in cycle k+1; freeze high in cycle k+1 only; next request can be accepted at edge k+2.
  - mul: low byte in cycle k+1, high byte in cycle k+2; freeze high in cycles k+1..k+2; st_done pulses in cycle k+2.
- Halt-only request at edge k: halted_out=1 and freeze=1 from cycle k+1.
- Store with halted=1 (add) accepted at edge k: write in cycle k+1, halted_out=1 from cycle k+2.
- rst asserted mid-store, at any phase: the block returns to reset values immediately; mem_we drops asynchronously and the remaining byte is not written.

## Structure
- Shared package core_pkg holds:
  - st state enum (IDLE, WR_LO, WR_HI, HALT)
  - ADR_W and DATA_W defaults
- Single flat module; no sub-module. The saturating counter is small enough to stay inline.

## Test plan
- Add store, adr=0x05, result=0x00A7 -> one cycle with mem_we=1, adr 0x05, data 0xA7; freeze high for 1 cycle; st_done in the same cycle; wr_count=1.
- Mul store, adr=0x3F, result=0xBEEF -> writes 0xEF@0x3F, then 0xBE@0x00 (wrap); freeze high for 2 cycles; st_done only on the second write.
- New request held stable during freeze after a mul -> it is accepted exactly once, at the first IDLE edge; there is no duplicate write.
- Mul store with halted=1, adr=0x10 -> both bytes written, then halted_out=1 and freeze=1 permanently; later valid stores produce no mem_we.
- rst pulsed in WR_LO of a mul -> no high-byte write; all outputs at reset values; wr_count=0.
- 300 consecutive add stores -> wr_count saturates at 255 and does not wrap.
